// File: rtl/dru_pkg.sv
// dru_pkg: shared state encoding and constants for the DRU word aligner
package dru_pkg;
  typedef enum logic {HUNT, LOCKED} state_t;
  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] DEF_SYNC = 8'hBC;
endpackage

// File: rtl/dru_sync_match.sv
// dru_sync_match: compares the up-to-three windows ending at new bits against the sync word, earliest-ending wins
module dru_sync_match
  import dru_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD = DEF_SYNC
) (
  input  logic [9:0] i_hist,
  input  logic [1:0] i_n,
  input  logic [3:0] i_avail,
  output logic       o_hit,
  output logic [1:0] o_pos
);
  logic [2:0] w_m;
  for (genvar p = 0; p < 3; p++) begin : g_win
    assign w_m[p] = (2'(p) < i_n) && (i_avail >= 4'(p + 8)) && (i_hist[p+7:p] == SYNC_WORD);
  end
  assign o_hit = |w_m;
  assign o_pos = w_m[2] ? 2'd2 : w_m[1] ? 2'd1 : 2'd0;
endmodule

// File: rtl/dru_word_aligner.sv
// dru_word_aligner: hunts for the sync word in a 0..3 bit/cycle stream and emits aligned 8-bit words
module dru_word_aligner
  import dru_pkg::*;
#(
  parameter logic [WORD_W-1:0] SYNC_WORD     = DEF_SYNC,
  parameter int                TIMEOUT_WORDS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] bits_in,
  input  logic [1:0] num_bits,
  input  logic       in_valid,
  input  logic       realign,
  output logic [7:0] word_out,
  output logic       word_valid,
  output logic       word_is_sync,
  output logic       locked,
  output logic [7:0] relock_count
);
  state_t      r_state;
  logic [9:0]  r_acc;
  logic [3:0]  r_cnt;
  logic [15:0] r_wcnt;
  logic [7:0]  r_word;
  logic        r_valid;
  logic        r_sync;
  logic [7:0]  r_relock;
  logic [1:0]  w_sh;
  logic [2:0]  w_ins;
  logic [9:0]  w_new;
  logic [3:0]  w_tot;
  logic        w_step;
  logic        w_hit;
  logic [1:0]  w_pos;
  logic [7:0]  w_word;
  logic        w_is_sync;
  logic        w_emit;
  logic        w_tmo;
  assign w_sh      = 2'd3 - num_bits;
  assign w_ins     = bits_in << w_sh;
  assign w_new     = 10'(({r_acc, 3'b000} | {10'd0, w_ins}) >> w_sh);
  assign w_tot     = r_cnt + {2'b00, num_bits};
  assign w_step    = in_valid && (num_bits != 2'd0);
  assign w_word    = 8'(w_new >> (w_tot - 4'd8));
  assign w_is_sync = (w_word == SYNC_WORD);
  assign w_emit    = w_step && (r_state == LOCKED) && (w_tot >= 4'd8);
  assign w_tmo     = w_emit && !w_is_sync && (r_wcnt + 16'd1 == 16'(TIMEOUT_WORDS));
  dru_sync_match #(.SYNC_WORD(SYNC_WORD)) u_match (
    .i_hist (w_new),
    .i_n    (num_bits),
    .i_avail(w_tot),
    .o_hit  (w_hit),
    .o_pos  (w_pos)
  );
  // alignment FSM, bit accumulator, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= HUNT;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_wcnt   <= '0;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_sync   <= 1'b0;
      r_relock <= '0;
    end else begin
      r_valid <= 1'b0;
      r_sync  <= 1'b0;
      if (realign) begin
        r_state <= HUNT;
        r_cnt   <= '0;
        r_wcnt  <= '0;
      end else if (w_step) begin
        r_acc <= w_new;
        if (r_state == HUNT) begin
          if (w_hit) begin
            r_state <= LOCKED;
            r_cnt   <= {2'b00, w_pos};
            r_wcnt  <= '0;
            r_valid <= 1'b1;
            r_sync  <= 1'b1;
            r_word  <= SYNC_WORD;
          end else begin
            r_cnt <= (w_tot > 4'd10) ? 4'd10 : w_tot;
          end
        end else if (w_emit) begin
          r_valid <= 1'b1;
          r_sync  <= w_is_sync;
          r_word  <= w_word;
          if (w_tmo) begin
            r_state  <= HUNT;
            r_cnt    <= '0;
            r_wcnt   <= '0;
            r_relock <= r_relock + {7'd0, r_relock != 8'hFF};
          end else begin
            r_cnt  <= w_tot - 4'd8;
            r_wcnt <= w_is_sync ? 16'd0 : r_wcnt + 16'd1;
          end
        end else begin
          r_cnt <= w_tot;
        end
      end
    end
  end
  assign word_out     = r_word;
  assign word_valid   = r_valid;
  assign word_is_sync = r_sync;
  assign locked       = (r_state == LOCKED);
  assign relock_count = r_relock;
endmodule
